id_ex_stage: RTL and testbench

//  ID/EX pipeline register directly upstream of the ALU. Captures a decoded instruction, resolves RAW hazards
//  (forwarding from EX/MEM/WB, load-use stall) and selects the ALU operands.

---
 rtl/id_ex_stage_if.sv | 36 +++
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 tb/tb_id_ex_stage.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode -> ID/EX handshake and decoded-instruction bundle.
//   master : decode side, drives in_valid and the id_* fields, sees in_ready
//   slave  : ID/EX stage side, samples in_valid and the id_* fields, drives in_ready
interface id_ex_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OPW  = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_val;
    logic [XLEN-1:0] id_rs2_val;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [OPW-1:0]  id_aluop;
    logic [1:0]      id_asel;
    logic            id_bsel;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            id_regwrite;
    logic            id_memread;

    modport master (
        output in_valid, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rs1, id_rs2, id_rd,
               id_aluop, id_asel, id_bsel, id_use_rs1, id_use_rs2, id_regwrite, id_memread,
        input  in_ready
    );

    modport slave (
        input  in_valid, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rs1, id_rs2, id_rd,
               id_aluop, id_asel, id_bsel, id_use_rs1, id_use_rs2, id_regwrite, id_memread,
        output in_ready
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
// Captures a decoded instruction, forwards operands from EX/MEM/WB, stalls on load-use,
// and presents the selected ALU operands, ALUOp and control on ex_*.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   dec                decode handshake + instruction fields (slave side)
//   flush              kill the held instruction and refuse the incoming one
//   ex_ready           downstream consumes ex_* this cycle
//   alu_c              ALU result of the instruction currently on ex_*
//   mem_*/wb_*         later-stage writeback forward sources
//   ex_*               registered ALU operands and control toward EX
//   load_use_stall     combinational hazard indicator
module id_ex_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OPW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    id_ex_stage_if.slave    dec,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic [XLEN-1:0] alu_c,
    input  logic [4:0]      mem_rd,
    input  logic            mem_regwrite,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd,
    input  logic            wb_regwrite,
    input  logic [XLEN-1:0] wb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [OPW-1:0]  ex_aluop,
    output logic [4:0]      ex_rd,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic [XLEN-1:0] ex_store_data,
    output logic            load_use_stall
);

    localparam logic [OPW-1:0] AluNop = '0;

    logic            ex_valid_q;
    logic [XLEN-1:0] ex_a_q;
    logic [XLEN-1:0] ex_b_q;
    logic [OPW-1:0]  ex_aluop_q;
    logic [4:0]      ex_rd_q;
    logic            ex_regwrite_q;
    logic            ex_memread_q;
    logic [XLEN-1:0] ex_store_data_q;

    logic            adv;
    logic            capture;
    logic            ex_fwd_ok;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] a_sel;
    logic [XLEN-1:0] b_sel;

    assign adv = !ex_valid_q || ex_ready;

    always_comb begin
        load_use_stall = dec.in_valid && ex_valid_q && ex_memread_q && (ex_rd_q != 5'd0) &&
                         ((dec.id_use_rs1 && (dec.id_rs1 == ex_rd_q)) ||
                          (dec.id_use_rs2 && (dec.id_rs2 == ex_rd_q)));
    end

    assign dec.in_ready = adv && !load_use_stall && !flush;
    assign capture      = dec.in_valid && dec.in_ready;

    // A load in EX has no result yet; it is covered by the load-use stall instead.
    assign ex_fwd_ok = ex_valid_q && ex_regwrite_q && !ex_memread_q;

    // Priority EX > MEM > WB > regfile; x0 always takes the regfile value.
    always_comb begin
        rs1_fwd = dec.id_rs1_val;
        if (dec.id_rs1 != 5'd0) begin
            if (ex_fwd_ok && (ex_rd_q == dec.id_rs1)) begin
                rs1_fwd = alu_c;
            end else if (mem_regwrite && (mem_rd == dec.id_rs1)) begin
                rs1_fwd = mem_result;
            end else if (wb_regwrite && (wb_rd == dec.id_rs1)) begin
                rs1_fwd = wb_result;
            end
        end
    end

    always_comb begin
        rs2_fwd = dec.id_rs2_val;
        if (dec.id_rs2 != 5'd0) begin
            if (ex_fwd_ok && (ex_rd_q == dec.id_rs2)) begin
                rs2_fwd = alu_c;
            end else if (mem_regwrite && (mem_rd == dec.id_rs2)) begin
                rs2_fwd = mem_result;
            end else if (wb_regwrite && (wb_rd == dec.id_rs2)) begin
                rs2_fwd = wb_result;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        unique case (dec.id_asel)
            2'b00:   a_sel = rs1_fwd;
            2'b01:   a_sel = dec.id_pc;
            default: a_sel = '0;
        endcase
        b_sel = dec.id_bsel ? dec.id_imm : rs2_fwd;
    end

    // Flush forces in_ready low, so it always lands in the bubble branch even when stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q      <= 1'b0;
            ex_a_q          <= '0;
            ex_b_q          <= '0;
            ex_aluop_q      <= AluNop;
            ex_rd_q         <= 5'd0;
            ex_regwrite_q   <= 1'b0;
            ex_memread_q    <= 1'b0;
            ex_store_data_q <= '0;
        end else if (capture) begin
            ex_valid_q      <= 1'b1;
            ex_a_q          <= a_sel;
            ex_b_q          <= b_sel;
            ex_aluop_q      <= dec.id_aluop;
            ex_rd_q         <= dec.id_rd;
            ex_regwrite_q   <= dec.id_regwrite;
            ex_memread_q    <= dec.id_memread;
            ex_store_data_q <= rs2_fwd;
        end else if (adv || flush) begin
            // Bubble: kill control, keep datapath fields as they were.
            ex_valid_q      <= 1'b0;
            ex_aluop_q      <= AluNop;
            ex_regwrite_q   <= 1'b0;
            ex_memread_q    <= 1'b0;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_a          = ex_a_q;
    assign ex_b          = ex_b_q;
    assign ex_aluop      = ex_aluop_q;
    assign ex_rd         = ex_rd_q;
    assign ex_regwrite   = ex_valid_q && ex_regwrite_q;
    assign ex_memread    = ex_valid_q && ex_memread_q;
    assign ex_store_data = ex_store_data_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage.
// Expected ex_* bundles are queued when an instruction is offered for capture and
// compared when the stage hands it downstream (ex_valid && ex_ready).
module tb_id_ex_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ex_ready;
    logic [31:0] alu_c;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_result;
    logic        ex_valid;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [4:0]  ex_aluop;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic [31:0] ex_store_data;
    logic        load_use_stall;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    id_ex_stage_if #(.XLEN(32), .OPW(5)) dec ();

    id_ex_stage #(.XLEN(32), .OPW(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .dec            (dec),
        .flush          (flush),
        .ex_ready       (ex_ready),
        .alu_c          (alu_c),
        .mem_rd         (mem_rd),
        .mem_regwrite   (mem_regwrite),
        .mem_result     (mem_result),
        .wb_rd          (wb_rd),
        .wb_regwrite    (wb_regwrite),
        .wb_result      (wb_result),
        .ex_valid       (ex_valid),
        .ex_a           (ex_a),
        .ex_b           (ex_b),
        .ex_aluop       (ex_aluop),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_store_data  (ex_store_data),
        .load_use_stall (load_use_stall)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare each instruction as it leaves the stage.
    always @(negedge clk) begin
        exp_t exp_v;
        exp_t act_v;
        if (!rst && ex_valid === 1'b1 && ex_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: got a=%h b=%h op=%0d rd=%0d, want no instruction",
                         ex_a, ex_b, ex_aluop, ex_rd);
            end else begin
                exp_v = sb.pop_front();
                act_v = '{a: ex_a, b: ex_b, sd: ex_store_data, op: ex_aluop, rd: ex_rd,
                          rw: ex_regwrite, mr: ex_memread};
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL sb_compare: got a=%h b=%h sd=%h op=%0d rd=%0d rw=%b mr=%b, want a=%h b=%h sd=%h op=%0d rd=%0d rw=%b mr=%b",
                             act_v.a, act_v.b, act_v.sd, act_v.op, act_v.rd, act_v.rw, act_v.mr,
                             exp_v.a, exp_v.b, exp_v.sd, exp_v.op, exp_v.rd, exp_v.rw, exp_v.mr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dec.in_valid    = 1'b0;
        dec.id_pc       = '0;
        dec.id_rs1_val  = '0;
        dec.id_rs2_val  = '0;
        dec.id_imm      = '0;
        dec.id_rs1      = '0;
        dec.id_rs2      = '0;
        dec.id_rd       = '0;
        dec.id_aluop    = '0;
        dec.id_asel     = '0;
        dec.id_bsel     = 1'b0;
        dec.id_use_rs1  = 1'b0;
        dec.id_use_rs2  = 1'b0;
        dec.id_regwrite = 1'b0;
        dec.id_memread  = 1'b0;
        flush           = 1'b0;
        ex_ready        = 1'b1;
        alu_c           = '0;
        mem_rd          = '0;
        mem_regwrite    = 1'b0;
        mem_result      = '0;
        wb_rd           = '0;
        wb_regwrite     = 1'b0;
        wb_result       = '0;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [31:0] r1v,
                             input logic [31:0] r2v, input logic [31:0] imm,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [4:0] op, input logic [1:0] asel, input logic bsel,
                             input logic u1, input logic u2, input logic rw, input logic mr);
        dec.in_valid    = 1'b1;
        dec.id_pc       = pc;
        dec.id_rs1_val  = r1v;
        dec.id_rs2_val  = r2v;
        dec.id_imm      = imm;
        dec.id_rs1      = rs1;
        dec.id_rs2      = rs2;
        dec.id_rd       = rd;
        dec.id_aluop    = op;
        dec.id_asel     = asel;
        dec.id_bsel     = bsel;
        dec.id_use_rs1  = u1;
        dec.id_use_rs2  = u2;
        dec.id_regwrite = rw;
        dec.id_memread  = mr;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                            input logic [4:0] op, input logic [4:0] rd, input logic rw,
                            input logic mr);
        sb.push_back('{a: a, b: b, sd: sd, op: op, rd: rd, rw: rw, mr: mr});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
        total++; if (ex_aluop !== 5'd0) begin bad++; $display("FAIL reset_aluop: got %0d want 0", ex_aluop); end
        total++; if (ex_a !== 32'd0) begin bad++; $display("FAIL reset_a: got %h want 0", ex_a); end
        total++; if (ex_b !== 32'd0) begin bad++; $display("FAIL reset_b: got %h want 0", ex_b); end
        total++; if (ex_regwrite !== 1'b0 || ex_memread !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: got rw=%b mr=%b want 0 0", ex_regwrite, ex_memread);
        end
        total++; if (dec.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", dec.in_ready); end
        step();
    endtask

    task automatic test_addi();
        set_instr(32'h100, 32'h10, 32'h99, 32'h7, 5'd5, 5'd0, 5'd6, 5'd3, 2'b00, 1'b1,
                  1'b1, 1'b0, 1'b1, 1'b0);
        push_exp(32'h10, 32'h7, 32'h99, 5'd3, 5'd6, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (dec.in_ready !== 1'b1) begin bad++; $display("FAIL addi_in_ready: got %b want 1", dec.in_ready); end
        step();
        clear_inputs();
        @(negedge clk);
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL addi_valid: got %b want 1", ex_valid); end
        step();
    endtask

    task automatic test_back_to_back();
        // Producer add rd=x5.
        set_instr(32'h200, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd5, 5'd3, 2'b00, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(32'h1, 32'h2, 32'h2, 5'd3, 5'd5, 1'b1, 1'b0);
        step();
        // EX (0x55) must beat MEM (0x11) for x5; rs2=x0 takes regfile data.
        alu_c = 32'h55; mem_rd = 5'd5; mem_regwrite = 1'b1; mem_result = 32'h11;
        set_instr(32'h204, 32'h10, 32'h3, 32'h0, 5'd5, 5'd0, 5'd6, 5'd3, 2'b00, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(32'h55, 32'h3, 32'h3, 5'd3, 5'd6, 1'b1, 1'b0);
        step();
        // Producer writing x0.
        clear_inputs();
        set_instr(32'h208, 32'h7, 32'h8, 32'h0, 5'd1, 5'd2, 5'd0, 5'd3, 2'b00, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(32'h7, 32'h8, 32'h8, 5'd3, 5'd0, 1'b1, 1'b0);
        step();
        // x0 consumer: no source may forward into index 0.
        alu_c = 32'h55; mem_rd = 5'd0; mem_regwrite = 1'b1; mem_result = 32'h11;
        wb_rd = 5'd0; wb_regwrite = 1'b1; wb_result = 32'h22;
        set_instr(32'h20c, 32'h0, 32'h0, 32'h4, 5'd0, 5'd0, 5'd10, 5'd3, 2'b00, 1'b1,
                  1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(32'h0, 32'h4, 32'h0, 5'd3, 5'd10, 1'b1, 1'b0);
        step();
        // MEM beats WB for x9.
        mem_rd = 5'd9; mem_result = 32'h11; wb_rd = 5'd9; wb_result = 32'h22;
        set_instr(32'h210, 32'haa, 32'hbb, 32'h0, 5'd9, 5'd12, 5'd13, 5'd3, 2'b00, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(32'h11, 32'hbb, 32'hbb, 5'd3, 5'd13, 1'b1, 1'b0);
        step();
        // WB alone supplies rs2=x12 for both B and store data.
        wb_rd = 5'd12; wb_result = 32'h33;
        set_instr(32'h214, 32'h5, 32'hbb, 32'h0, 5'd5, 5'd12, 5'd14, 5'd3, 2'b00, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(32'h5, 32'h33, 32'h33, 5'd3, 5'd14, 1'b1, 1'b0);
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_load_use();
        set_instr(32'h300, 32'h1000, 32'h0, 32'h4, 5'd2, 5'd0, 5'd7, 5'd3, 2'b00, 1'b1,
                  1'b1, 1'b0, 1'b1, 1'b1);
        push_exp(32'h1000, 32'h4, 32'h0, 5'd3, 5'd7, 1'b1, 1'b1);
        step();
        set_instr(32'h304, 32'h20, 32'hdead, 32'h0, 5'd3, 5'd7, 5'd8, 5'd3, 2'b00, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (load_use_stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got %b want 1", load_use_stall); end
        total++; if (dec.in_ready !== 1'b0) begin bad++; $display("FAIL lu_in_ready: got %b want 0", dec.in_ready); end
        step();
        // Load has moved to MEM; its data arrives on the MEM forward path.
        mem_rd = 5'd7; mem_regwrite = 1'b1; mem_result = 32'h77;
        push_exp(32'h20, 32'h77, 32'h77, 5'd3, 5'd8, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (ex_valid !== 1'b0 || ex_aluop !== 5'd0) begin
            bad++; $display("FAIL lu_bubble: got valid=%b op=%0d want 0 0", ex_valid, ex_aluop);
        end
        total++; if (ex_a !== 32'h1000) begin bad++; $display("FAIL lu_bubble_hold_a: got %h want 00001000", ex_a); end
        total++; if (load_use_stall !== 1'b0 || dec.in_ready !== 1'b1) begin
            bad++; $display("FAIL lu_release: got stall=%b ready=%b want 0 1", load_use_stall, dec.in_ready);
        end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_backpressure();
        set_instr(32'h400, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, 5'd3, 2'b00, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(32'h1, 32'h2, 32'h2, 5'd3, 5'd3, 1'b1, 1'b0);
        step();
        ex_ready = 1'b0;
        set_instr(32'h404, 32'ha, 32'hb, 32'h0, 5'd4, 5'd6, 5'd11, 5'd3, 2'b00, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (dec.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, dec.in_ready); end
            total++; if (ex_valid !== 1'b1 || ex_a !== 32'h1 || ex_b !== 32'h2 || ex_rd !== 5'd3) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got valid=%b a=%h b=%h rd=%0d want 1 00000001 00000002 3",
                         i, ex_valid, ex_a, ex_b, ex_rd);
            end
            step();
        end
        ex_ready = 1'b1;
        push_exp(32'ha, 32'hb, 32'hb, 5'd3, 5'd11, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (dec.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got %b want 1", dec.in_ready); end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_flush();
        exp_t dropped;
        set_instr(32'h500, 32'h3, 32'h4, 32'h0, 5'd1, 5'd2, 5'd3, 5'd3, 2'b00, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(32'h3, 32'h4, 32'h4, 5'd3, 5'd3, 1'b1, 1'b0);
        step();
        ex_ready = 1'b0;
        flush    = 1'b1;
        set_instr(32'h504, 32'h5, 32'h6, 32'h0, 5'd1, 5'd2, 5'd4, 5'd3, 2'b00, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (dec.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", dec.in_ready); end
        step();
        // The held instruction was killed and will never reach downstream.
        dropped = sb.pop_front();
        clear_inputs();
        @(negedge clk);
        total++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_aluop !== 5'd0) begin
            bad++;
            $display("FAIL flush_bubble: got valid=%b rw=%b op=%0d want 0 0 0 (killed rd=%0d)",
                     ex_valid, ex_regwrite, ex_aluop, dropped.rd);
        end
        step();
        set_instr(32'h508, 32'hffff, 32'h0, 32'h12345000, 5'd1, 5'd0, 5'd1, 5'd1, 2'b10, 1'b1,
                  1'b0, 1'b0, 1'b1, 1'b0);
        push_exp(32'h0, 32'h12345000, 32'h0, 5'd1, 5'd1, 1'b1, 1'b0);
        step();
        clear_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_load_use();
        test_backpressure();
        test_flush();
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
